keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Drives the 4x4 matrix keypad column lines and reads back the row lines on the same `row_in`/`col_out` pins the top-level exposes.
- Debounces key presses and emits one decoded 4-bit key code per accepted press, as a single-cycle `key_valid` pulse.
- Consumers are the CPU MMIO input path and the seven-segment display logic.
- Sits directly behind the board keypad pins in the top level.

Parameters:
- SCAN_CYCLES, 10000, clk cycles each column is driven (100 us at 100 MHz); must be >= 4.
- DEBOUNCE_FRAMES, 4, consecutive identical full-scan frames required to accept a press or a release; must be >= 1.
- REPEAT_FRAMES, 250, frames between auto-repeat pulses; used only with KEYPAD_REPEAT_EN.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- row_in  input  4  keypad rows, active-low, pulled up (1111 = nothing pressed)
- col_out  output  4  keypad column drive, active-low one-hot
- key_code  output  4  code of last accepted key, held until next accept
- key_valid  output  1  one-cycle pulse when key_code is updated
- key_pressed  output  1  level, high while an accepted key is held

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low. All flops clear immediately on `rst_n`=0.
- Reset values: col_out=4'b1110, key_code=4'h0, key_valid=0, key_pressed=0. Counters, synchronizer, frame result and FSM also clear.
- Input sync: row_in passes through a 2-flop synchronizer (reset to 1111) before any use.
- Column scan:
  - Dwell counter runs 0..SCAN_CYCLES-1 per column.
  - On the terminal count, the synchronized rows are sampled for the current column, then col_out rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - Column index c = position of the 0 bit in col_out.
- Frame:
  - One frame = 4 column samples, columns 0..3 in order.
  - Frame hit = first sample in scan order with any row low. Within that sample the lowest-index low row r wins. Result is (r,c).
  - No low row in any sample = empty frame.
  - Frame result is evaluated at the terminal count of column 3.
- Key map (row r, col c -> code):
  - r0: 1,2,3,A -> 1,2,3,A
  - r1: 4,5,6,B -> 4,5,6,B
  - r2: 7,8,9,C -> 7,8,9,C
  - r3: *,0,#,D -> E,0,F,D
- FSM, evaluated once per frame end, with frame counter fcnt:
  - IDLE: hit -> PRESS_DB, latch candidate, fcnt=1. Empty -> stay.
  - PRESS_DB:
    - hit equal to candidate -> fcnt+1.
    - hit different -> new candidate, fcnt=1.
    - empty -> IDLE.
    - When fcnt reaches DEBOUNCE_FRAMES -> HELD, key_code<=candidate, key_valid=1 for exactly one cycle (the cycle after the frame end), key_pressed=1.
    - With DEBOUNCE_FRAMES=1 the first hit frame accepts directly.
  - HELD: empty -> REL_DB, fcnt=1. Any hit, including a different key, -> stay. There is no rollover; a second key is ignored until full release.
  - REL_DB: empty -> fcnt+1. Hit -> HELD. When fcnt reaches DEBOUNCE_FRAMES -> IDLE, key_pressed=0, no pulse.
- Press latency: DEBOUNCE_FRAMES frames from the first hit frame, plus 1 cycle, plus sync delay.
- Release latency: DEBOUNCE_FRAMES empty frames.
- Width rules: dwell counter is $clog2(SCAN_CYCLES) bits. Frame counter saturates and never wraps.
- key_valid is never high on two consecutive cycles.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter counts frames from accept.
  - Every REPEAT_FRAMES frames it re-pulses key_valid for one cycle with key_code unchanged.
  - Counter clears on leaving HELD. REL_DB pauses the count; returning to HELD resumes it.
- Undefined: exactly one key_valid per press; REPEAT_FRAMES is unused.

Test Plan:
- Bench setup: SCAN_CYCLES=4, DEBOUNCE_FRAMES=2, REPEAT_FRAMES=3. The keypad model pulls row r low only while col_out bit c is low.
- Reset: rst_n=0 asynchronously mid-cycle -> immediately col_out=1110, key_code=0, key_valid=0, key_pressed=0. After release, col_out=1101 after 4 cycles, 0111 after 12.
- Single press: key '5' (r1,c1) held 10 frames -> exactly one key_valid, key_code=4'h5, key_pressed=1 from frame 2. On release, key_pressed=0 after 2 empty frames, no extra pulse.
- Bounce: '#' (r3,c2) held for 1 frame, then released -> no key_valid, key_pressed stays 0, key_code unchanged.
- Simultaneous keys: '1' (r0,c0) and 'D' (r3,c3) pressed together -> key_code=4'h1. Then press 'D' alone while '1' still held -> no new pulse until both released.
- Unscanned stimulus: row_in forced to 1101 regardless of columns for 10 frames -> key_code=4'h4 (r1,c0), one pulse. Reset asserted during PRESS_DB -> no pulse.
- KEYPAD_REPEAT_EN defined: hold 'A' 12 frames -> pulses at accept, then at +3, +6 and +9 frames, all with key_code=4'hA. Undefined: exactly 1 pulse.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sync, frame-based debounce, key decode.
// Optional auto-repeat of key_valid while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int unsigned SCAN_CYCLES     = 10000,
  parameter int unsigned DEBOUNCE_FRAMES = 4,
  parameter int unsigned REPEAT_FRAMES   = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam int unsigned DWELL_W = $clog2(SCAN_CYCLES);
  localparam int unsigned FCNT_W  = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST  = DWELL_W'(SCAN_CYCLES - 1);
  localparam logic [FCNT_W-1:0]  FCNT_TARGET = FCNT_W'(DEBOUNCE_FRAMES);
  localparam logic [FCNT_W-1:0]  FCNT_ONE    = FCNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_DB,
    S_HELD,
    S_REL_DB
  } state_e;

  // Matrix position {row, col} to key code.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  // Lowest-index active-low row wins.
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    logic [1:0] r;
    if (!rows[0])      r = 2'd0;
    else if (!rows[1]) r = 2'd1;
    else if (!rows[2]) r = 2'd2;
    else               r = 2'd3;
    return r;
  endfunction

  logic [3:0]         row_meta_q, row_meta_d;
  logic [3:0]         row_sync_q, row_sync_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [3:0]         col_q, col_d;
  logic [1:0]         col_idx_q, col_idx_d;
  logic               acc_hit_q, acc_hit_d;
  logic [3:0]         acc_code_q, acc_code_d;
  state_e             state_q, state_d;
  logic [3:0]         cand_q, cand_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic [3:0]         key_code_q, key_code_d;
  logic               key_valid_q, key_valid_d;
  logic               key_pressed_q, key_pressed_d;

  logic               terminal_c;
  logic               frame_end_c;
  logic               sample_hit_c;
  logic [3:0]         sample_code_c;
  logic               frame_hit_c;
  logic [3:0]         frame_code_c;
  logic [FCNT_W-1:0]  fcnt_inc_c;
  logic               accept_c;
  logic               release_c;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RPT_W-1:0] RPT_TARGET = RPT_W'(REPEAT_FRAMES);
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
`else
  // REPEAT_FRAMES has no role without auto-repeat.
  logic [31:0] repeat_frames_unused;
  assign repeat_frames_unused = 32'(REPEAT_FRAMES);
`endif

  assign terminal_c    = (dwell_q == DWELL_LAST);
  assign frame_end_c   = terminal_c && (col_idx_q == 2'd3);
  assign sample_hit_c  = (row_sync_q != 4'hF);
  assign sample_code_c = key_map(low_row(row_sync_q), col_idx_q);
  assign frame_hit_c   = acc_hit_q || sample_hit_c;
  assign frame_code_c  = acc_hit_q ? acc_code_q : sample_code_c;
  assign fcnt_inc_c    = (fcnt_q == FCNT_TARGET) ? fcnt_q : fcnt_q + FCNT_ONE;

  // Scan sequencing, frame accumulation and debounce FSM next-state.
  always_comb begin
    row_meta_d    = row_in;
    row_sync_d    = row_meta_q;
    dwell_d       = terminal_c ? '0 : dwell_q + DWELL_W'(1);
    col_d         = col_q;
    col_idx_d     = col_idx_q;
    acc_hit_d     = acc_hit_q;
    acc_code_d    = acc_code_q;
    state_d       = state_q;
    cand_d        = cand_q;
    fcnt_d        = fcnt_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_pressed_d = key_pressed_q;
    accept_c      = 1'b0;
    release_c     = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_cnt_d     = rpt_cnt_q;
`endif

    if (terminal_c) begin
      col_d     = {col_q[2:0], col_q[3]};
      col_idx_d = col_idx_q + 2'd1;
      if (frame_end_c) begin
        acc_hit_d  = 1'b0;
        acc_code_d = 4'h0;
      end else if (!acc_hit_q && sample_hit_c) begin
        acc_hit_d  = 1'b1;
        acc_code_d = sample_code_c;
      end
    end

    if (frame_end_c) begin
      case (state_q)
        S_IDLE: begin
          if (frame_hit_c) begin
            cand_d = frame_code_c;
            fcnt_d = FCNT_ONE;
            if (FCNT_ONE == FCNT_TARGET) accept_c = 1'b1;
            else                         state_d  = S_PRESS_DB;
          end
        end
        S_PRESS_DB: begin
          if (!frame_hit_c) begin
            state_d = S_IDLE;
            fcnt_d  = '0;
          end else if (frame_code_c == cand_q) begin
            fcnt_d = fcnt_inc_c;
            if (fcnt_inc_c == FCNT_TARGET) accept_c = 1'b1;
          end else begin
            cand_d = frame_code_c;
            fcnt_d = FCNT_ONE;
          end
        end
        S_HELD: begin
          if (!frame_hit_c) begin
            fcnt_d = FCNT_ONE;
            if (FCNT_ONE == FCNT_TARGET) release_c = 1'b1;
            else                         state_d   = S_REL_DB;
          end else begin
`ifdef KEYPAD_REPEAT_EN
            if (rpt_cnt_q + RPT_W'(1) == RPT_TARGET) begin
              rpt_cnt_d   = '0;
              key_valid_d = 1'b1;
            end else begin
              rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
`endif
          end
        end
        S_REL_DB: begin
          if (frame_hit_c) begin
            state_d = S_HELD;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_inc_c;
            if (fcnt_inc_c == FCNT_TARGET) release_c = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          fcnt_d  = '0;
        end
      endcase
    end

    // Accepted press: latch code, pulse once, raise the held level.
    if (accept_c) begin
      state_d       = S_HELD;
      fcnt_d        = '0;
      key_code_d    = cand_d;
      key_valid_d   = 1'b1;
      key_pressed_d = 1'b1;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt_d     = '0;
`endif
    end

    if (release_c) begin
      state_d       = S_IDLE;
      fcnt_d        = '0;
      key_pressed_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt_d     = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q    <= 4'hF;
      row_sync_q    <= 4'hF;
      dwell_q       <= '0;
      col_q         <= 4'b1110;
      col_idx_q     <= 2'd0;
      acc_hit_q     <= 1'b0;
      acc_code_q    <= 4'h0;
      state_q       <= S_IDLE;
      cand_q        <= 4'h0;
      fcnt_q        <= '0;
      key_code_q    <= 4'h0;
      key_valid_q   <= 1'b0;
      key_pressed_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt_q     <= '0;
`endif
    end else begin
      row_meta_q    <= row_meta_d;
      row_sync_q    <= row_sync_d;
      dwell_q       <= dwell_d;
      col_q         <= col_d;
      col_idx_q     <= col_idx_d;
      acc_hit_q     <= acc_hit_d;
      acc_code_q    <= acc_code_d;
      state_q       <= state_d;
      cand_q        <= cand_d;
      fcnt_q        <= fcnt_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_pressed_q <= key_pressed_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_cnt_q     <= rpt_cnt_d;
`endif
    end
  end

  assign col_out     = col_q;
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_pressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 matrix keypad model.
module tb_keypad_scanner;

  localparam int unsigned SCAN  = 4;
  localparam int unsigned DEB   = 2;
  localparam int unsigned RPT   = 3;
  localparam int unsigned FRAME = 4 * SCAN;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_pressed;

  logic [15:0] keys;
  logic        force_en;
  logic [3:0]  force_rows;

  int          vectors = 0;
  int          miscompares = 0;
  int          pulse_cnt = 0;
  logic [3:0]  last_code = 4'h0;
  logic        prev_valid = 1'b0;
  int          p0;
  int          exp_rpt;

  keypad_scanner #(
    .SCAN_CYCLES    (SCAN),
    .DEBOUNCE_FRAMES(DEB),
    .REPEAT_FRAMES  (RPT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .row_in     (row_in),
    .col_out    (col_out),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_pressed(key_pressed)
  );

  always #5 clk = ~clk;

  // Keypad: key (r,c) pulls row r low only while column c is driven low.
  always_comb begin
    row_in = 4'hF;
    if (force_en) begin
      row_in = force_rows;
    end else begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic frames(input int n);
    repeat (n * FRAME) @(posedge clk);
    @(negedge clk);
  endtask

  // Pulse monitor: counts key_valid pulses and rejects back-to-back highs.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (key_valid === 1'b1) begin
        check("valid_not_consecutive", {31'd0, prev_valid}, 32'd0);
        pulse_cnt++;
        last_code = key_code;
      end
      prev_valid = (key_valid === 1'b1);
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b1;
    keys       = 16'h0;
    force_en   = 1'b0;
    force_rows = 4'hF;

    // Asynchronous reset mid-cycle
    #3 rst_n = 1'b0;
    #1;
    check("rst_col_out", 32'(col_out), 32'h0E);
    check("rst_key_code", 32'(key_code), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_key_pressed", 32'(key_pressed), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Column rotation timing after reset release
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("col_after_4", 32'(col_out), 32'h0D);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("col_after_12", 32'(col_out), 32'h07);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("col_after_16", 32'(col_out), 32'h0E);

    // Single press of '5' for 10 frames, then release
    p0 = pulse_cnt;
    keys[1*4+1] = 1'b1;
    frames(1);
    check("p5_pressed_f1", 32'(key_pressed), 32'h0);
    check("p5_valid_f1", 32'(key_valid), 32'h0);
    frames(1);
    check("p5_pressed_f2", 32'(key_pressed), 32'h1);
    check("p5_valid_f2", 32'(key_valid), 32'h1);
    check("p5_code", 32'(key_code), 32'h5);
    frames(8);
    check("p5_pulses_held", 32'(pulse_cnt - p0), 32'd1);
    keys = 16'h0;
    frames(1);
    check("p5_pressed_rel1", 32'(key_pressed), 32'h1);
    frames(1);
    check("p5_pressed_rel2", 32'(key_pressed), 32'h0);
    check("p5_pulses_total", 32'(pulse_cnt - p0), 32'd1);
    check("p5_code_held", 32'(key_code), 32'h5);

    // Bounce: '#' for one frame only
    p0 = pulse_cnt;
    keys[3*4+2] = 1'b1;
    frames(1);
    check("bnc_pressed_f1", 32'(key_pressed), 32'h0);
    keys = 16'h0;
    frames(3);
    check("bnc_pulses", 32'(pulse_cnt - p0), 32'd0);
    check("bnc_pressed", 32'(key_pressed), 32'h0);
    check("bnc_code", 32'(key_code), 32'h5);

    // '1' and 'D' together; then 'D' alone stays ignored until full release
    p0 = pulse_cnt;
    keys[0*4+0] = 1'b1;
    keys[3*4+3] = 1'b1;
    frames(2);
    check("sim_code", 32'(key_code), 32'h1);
    check("sim_pressed", 32'(key_pressed), 32'h1);
    keys[0*4+0] = 1'b0;
    frames(3);
    check("sim_d_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("sim_d_code", 32'(key_code), 32'h1);
    check("sim_d_pressed", 32'(key_pressed), 32'h1);
    keys = 16'h0;
    frames(2);
    check("sim_rel_pressed", 32'(key_pressed), 32'h0);
    check("sim_rel_pulses", 32'(pulse_cnt - p0), 32'd1);

    // Rows forced to 1101 regardless of column drive
    p0 = pulse_cnt;
    force_en   = 1'b1;
    force_rows = 4'b1101;
    frames(10);
    check("frc_code", 32'(key_code), 32'h4);
    check("frc_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("frc_pressed", 32'(key_pressed), 32'h1);
    force_en = 1'b0;
    frames(2);
    check("frc_rel_pressed", 32'(key_pressed), 32'h0);

    // Reset while debouncing a press of '9'
    p0 = pulse_cnt;
    keys[2*4+2] = 1'b1;
    frames(1);
    check("rdb_pressed", 32'(key_pressed), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("rdb_col_out", 32'(col_out), 32'h0E);
    check("rdb_key_code", 32'(key_code), 32'h0);
    check("rdb_key_valid", 32'(key_valid), 32'h0);
    check("rdb_key_pressed", 32'(key_pressed), 32'h0);
    keys = 16'h0;
    @(negedge clk);
    rst_n = 1'b1;
    frames(3);
    check("rdb_pulses", 32'(pulse_cnt - p0), 32'd0);
    check("rdb_code_after", 32'(key_code), 32'h0);
    check("rdb_pressed_after", 32'(key_pressed), 32'h0);

    // Hold 'A' for 12 frames: auto-repeat when enabled, single pulse otherwise
`ifdef KEYPAD_REPEAT_EN
    exp_rpt = 4;
`else
    exp_rpt = 1;
`endif
    p0 = pulse_cnt;
    keys[0*4+3] = 1'b1;
    frames(12);
    check("rpt_code", 32'(key_code), 32'hA);
    keys = 16'h0;
    frames(2);
    check("rpt_pulses", 32'(pulse_cnt - p0), 32'(exp_rpt));
    check("rpt_last_code", 32'(last_code), 32'hA);
    check("rpt_pressed", 32'(key_pressed), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
